// File: rtl/mchan_resp_router_ipa_if.sv
// Response-path bundle of mchan_resp_router_ipa: one tagged input stream, two
// registered response ports, request-side grants and outstanding-count status.
interface mchan_resp_router_ipa_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int OUTST_WIDTH = 4
);
  logic                   valid_i;
  logic                   ready_o;
  logic [DATA_WIDTH-1:0]  data_i;
  logic [ID_WIDTH-1:0]    id_i;

  logic                   valid0_o;
  logic                   ready0_i;
  logic [DATA_WIDTH-1:0]  data0_o;
  logic [ID_WIDTH-1:0]    id0_o;

  logic                   valid1_o;
  logic                   ready1_i;
  logic [DATA_WIDTH-1:0]  data1_o;
  logic [ID_WIDTH-1:0]    id1_o;

  logic                   gnt0_i;
  logic                   gnt1_i;
  logic [OUTST_WIDTH-1:0] outst0_o;
  logic [OUTST_WIDTH-1:0] outst1_o;
  logic                   full0_o;
  logic                   full1_o;
  logic                   err_o;

  // Router side.
  modport slave (
    input  valid_i, data_i, id_i, ready0_i, ready1_i, gnt0_i, gnt1_i,
    output ready_o, valid0_o, data0_o, id0_o, valid1_o, data1_o, id1_o,
    output outst0_o, outst1_o, full0_o, full1_o, err_o
  );

  // Environment side: response producer, port consumers and request arbiter.
  modport master (
    output valid_i, data_i, id_i, ready0_i, ready1_i, gnt0_i, gnt1_i,
    input  ready_o, valid0_o, data0_o, id0_o, valid1_o, data1_o, id1_o,
    input  outst0_o, outst1_o, full0_o, full1_o, err_o
  );
endinterface

// File: rtl/mchan_resp_router_ipa.sv
// 1:2 response router: id_i[SEL_BIT] picks a registered output slot per beat.
// Outstanding-request tracking is compiled in with MCHAN_RESP_OUTST_CHECK_EN.
module mchan_resp_router_ipa #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int SEL_BIT     = ID_WIDTH-1,
  parameter int OUTST_WIDTH = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mchan_resp_router_ipa_if.slave bus
);

  logic                  sel_p0;
  logic                  free0_p0;
  logic                  free1_p0;
  logic                  ready_p0;
  logic                  acc0_p0;
  logic                  acc1_p0;

  logic                  vld0_p1;
  logic [DATA_WIDTH-1:0] data0_p1;
  logic [ID_WIDTH-1:0]   id0_p1;
  logic                  vld1_p1;
  logic [DATA_WIDTH-1:0] data1_p1;
  logic [ID_WIDTH-1:0]   id1_p1;

  // Stage p0: port select and acceptance. A slot draining this cycle counts as
  // free, so ready_o never depends on valid_i.
  assign sel_p0   = bus.id_i[SEL_BIT];
  assign free0_p0 = !vld0_p1 || bus.ready0_i;
  assign free1_p0 = !vld1_p1 || bus.ready1_i;
  assign ready_p0 = sel_p0 ? free1_p0 : free0_p0;
  assign acc0_p0  = bus.valid_i && ready_p0 && !sel_p0;
  assign acc1_p0  = bus.valid_i && ready_p0 &&  sel_p0;

  assign bus.ready_o = ready_p0;

  // Stage p1: one output slot per port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld0_p1  <= 1'b0;
      data0_p1 <= '0;
      id0_p1   <= '0;
    end else if (acc0_p0) begin
      vld0_p1  <= 1'b1;
      data0_p1 <= bus.data_i;
      id0_p1   <= bus.id_i;
    end else if (bus.ready0_i) begin
      vld0_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld1_p1  <= 1'b0;
      data1_p1 <= '0;
      id1_p1   <= '0;
    end else if (acc1_p0) begin
      vld1_p1  <= 1'b1;
      data1_p1 <= bus.data_i;
      id1_p1   <= bus.id_i;
    end else if (bus.ready1_i) begin
      vld1_p1  <= 1'b0;
    end
  end

  assign bus.valid0_o = vld0_p1;
  assign bus.data0_o  = data0_p1;
  assign bus.id0_o    = id0_p1;
  assign bus.valid1_o = vld1_p1;
  assign bus.data1_o  = data1_p1;
  assign bus.id1_o    = id1_p1;

`ifdef MCHAN_RESP_OUTST_CHECK_EN
  localparam logic [OUTST_WIDTH-1:0] CNT_MAX = '1;

  // Saturating up/down count: grant and response in one cycle cancel; the
  // count neither wraps above max nor below zero.
  function automatic logic [OUTST_WIDTH-1:0] cnt_sat(
    input logic [OUTST_WIDTH-1:0] cnt,
    input logic                   inc,
    input logic                   dec
  );
    logic [OUTST_WIDTH-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      res = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - 1'b1;
    end
    return res;
  endfunction

  logic [OUTST_WIDTH-1:0] cnt0_p1;
  logic [OUTST_WIDTH-1:0] cnt1_p1;
  logic                   full0_p1;
  logic                   full1_p1;
  logic                   err_p1;
  logic [OUTST_WIDTH-1:0] cnt0_nxt;
  logic [OUTST_WIDTH-1:0] cnt1_nxt;
  logic                   err_nxt;

  always_comb begin
    cnt0_nxt = cnt_sat(cnt0_p1, bus.gnt0_i, acc0_p0);
    cnt1_nxt = cnt_sat(cnt1_p1, bus.gnt1_i, acc1_p0);
    err_nxt  = (acc0_p0 && (cnt0_p1 == '0)) || (acc1_p0 && (cnt1_p1 == '0));
  end

  // Stage p1: counters; full flags and the error pulse register alongside them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0_p1  <= '0;
      cnt1_p1  <= '0;
      full0_p1 <= 1'b0;
      full1_p1 <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      cnt0_p1  <= cnt0_nxt;
      cnt1_p1  <= cnt1_nxt;
      full0_p1 <= (cnt0_nxt == CNT_MAX);
      full1_p1 <= (cnt1_nxt == CNT_MAX);
      err_p1   <= err_nxt;
    end
  end

  assign bus.outst0_o = cnt0_p1;
  assign bus.outst1_o = cnt1_p1;
  assign bus.full0_o  = full0_p1;
  assign bus.full1_o  = full1_p1;
  assign bus.err_o    = err_p1;
`else
  logic unused_gnt;
  assign unused_gnt   = bus.gnt0_i ^ bus.gnt1_i;

  assign bus.outst0_o = '0;
  assign bus.outst1_o = '0;
  assign bus.full0_o  = 1'b0;
  assign bus.full1_o  = 1'b0;
  assign bus.err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mchan_resp_router_ipa.sv
// Directed bench for mchan_resp_router_ipa; counter expectations follow
// whether MCHAN_RESP_OUTST_CHECK_EN is defined.
module tb_mchan_resp_router_ipa;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int OW = 4;
`ifdef MCHAN_RESP_OUTST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mchan_resp_router_ipa_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .OUTST_WIDTH(OW)) bus ();

  mchan_resp_router_ipa #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .SEL_BIT    (IW-1),
    .OUTST_WIDTH(OW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counter-related expectation: the value when tracking is built in, else 0.
  function automatic logic [63:0] cx(input logic [63:0] v);
    return CHK ? v : 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d);
    bus.valid_i = v;
    bus.id_i    = id;
    bus.data_i  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat(1'b0, '0, '0);
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b0;
    bus.gnt0_i   = 1'b0;
    bus.gnt1_i   = 1'b0;
    step();
    step();
    check("rst_valid0", bus.valid0_o, 0);
    check("rst_valid1", bus.valid1_o, 0);
    check("rst_data0",  bus.data0_o,  0);
    check("rst_id1",    bus.id1_o,    0);
    check("rst_outst0", bus.outst0_o, 0);
    check("rst_full1",  bus.full1_o,  0);
    check("rst_err",    bus.err_o,    0);
    rst = 1'b0;
    step();

    // Single beat to port1.
    bus.ready1_i = 1'b1;
    beat(1'b1, 4'h8, 32'hA5A5_0001);
    #1;
    check("single_ready", bus.ready_o, 1);
    step();
    beat(1'b0, '0, '0);
    check("single_valid1", bus.valid1_o, 1);
    check("single_data1",  bus.data1_o,  32'hA5A5_0001);
    check("single_id1",    bus.id1_o,    4'h8);
    check("single_valid0", bus.valid0_o, 0);
    check("single_err",    bus.err_o,    cx(1));
    step();
    check("single_drain",  bus.valid1_o, 0);
    check("single_err_off", bus.err_o,   0);

    // Streaming 8 beats to port0.
    bus.ready0_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 4'h3, 32'h1000 + i);
      #1;
      check("stream_ready", bus.ready_o, 1);
      step();
      check("stream_valid0", bus.valid0_o, 1);
      check("stream_data0",  bus.data0_o,  32'h1000 + i);
    end
    beat(1'b0, '0, '0);
    step();
    check("stream_end", bus.valid0_o, 0);

    // Backpressure on port1 while port0 keeps flowing.
    bus.ready1_i = 1'b0;
    beat(1'b1, 4'h9, 32'hB0);
    step();
    check("bp_fill_valid1", bus.valid1_o, 1);
    beat(1'b1, 4'h9, 32'hB1);
    #1;
    check("bp_ready_blocked", bus.ready_o, 0);
    step();
    check("bp_hold_data1", bus.data1_o, 32'hB0);
    beat(1'b1, 4'h1, 32'hC1);
    #1;
    check("bp_port0_ready", bus.ready_o, 1);
    step();
    check("bp_port0_valid", bus.valid0_o, 1);
    check("bp_port0_data",  bus.data0_o,  32'hC1);
    check("bp_hold_valid1", bus.valid1_o, 1);
    check("bp_hold_data1b", bus.data1_o,  32'hB0);
    bus.ready1_i = 1'b1;
    beat(1'b1, 4'h9, 32'hB1);
    #1;
    check("bp_refill_ready", bus.ready_o, 1);
    step();
    check("bp_refill_data1", bus.data1_o, 32'hB1);
    check("bp_refill_valid1", bus.valid1_o, 1);
    beat(1'b0, '0, '0);
    step();
    check("bp_drain_valid1", bus.valid1_o, 0);
    check("bp_drain_valid0", bus.valid0_o, 0);

    // Port0 outstanding counter.
    check("cnt_start", bus.outst0_o, 0);
    bus.gnt0_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("cnt_inc", bus.outst0_o, cx(i));
    end
    bus.gnt0_i = 1'b0;
    beat(1'b1, 4'h0, 32'hD0);
    for (int i = 2; i >= 0; i--) begin
      step();
      check("cnt_dec", bus.outst0_o, cx(i));
      check("cnt_dec_err", bus.err_o, 0);
    end
    beat(1'b0, '0, '0);
    bus.gnt0_i = 1'b1;
    step();
    check("cnt_one", bus.outst0_o, cx(1));
    beat(1'b1, 4'h0, 32'hD1);
    step();
    check("cnt_both", bus.outst0_o, cx(1));
    bus.gnt0_i = 1'b0;
    step();
    beat(1'b0, '0, '0);
    check("cnt_zero", bus.outst0_o, 0);
    check("cnt_zero_err", bus.err_o, 0);
    step();

    // Port1 saturation.
    bus.gnt1_i = 1'b1;
    for (int i = 1; i <= 14; i++) step();
    check("sat_14", bus.outst1_o, cx(14));
    check("sat_14_full", bus.full1_o, 0);
    step();
    check("sat_15", bus.outst1_o, cx(15));
    check("sat_15_full", bus.full1_o, cx(1));
    step();
    bus.gnt1_i = 1'b0;
    check("sat_16_hold", bus.outst1_o, cx(15));
    check("sat_16_full", bus.full1_o, cx(1));
    check("sat_full0", bus.full0_o, 0);

    // Response to port0 with nothing outstanding.
    beat(1'b1, 4'h2, 32'hE0);
    step();
    beat(1'b0, '0, '0);
    check("err_pulse", bus.err_o, cx(1));
    check("err_delivered", bus.valid0_o, 1);
    check("err_data0", bus.data0_o, 32'hE0);
    check("err_cnt0", bus.outst0_o, 0);
    step();
    check("err_one_cycle", bus.err_o, 0);

    // Asynchronous reset between edges.
    bus.ready0_i = 1'b0;
    beat(1'b1, 4'h4, 32'hF0);
    step();
    check("ar_pre_valid0", bus.valid0_o, 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid0", bus.valid0_o, 0);
    check("ar_data0",  bus.data0_o,  0);
    check("ar_id0",    bus.id0_o,    0);
    check("ar_outst1", bus.outst1_o, 0);
    check("ar_full1",  bus.full1_o,  0);
    beat(1'b0, '0, '0);
    step();
    rst = 1'b0;
    step();
    check("ar_after", bus.valid0_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
